// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one RGB ROM: per-port pending request capture,
// round-robin grant, one outstanding ROM read with a WAIT timeout.
module rom_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic [DATA_W-1:0] o_data0,
  output logic              o_valid0,
  input  logic              i_read1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic [DATA_W-1:0] o_data1,
  output logic              o_valid1,
  output logic              o_rom_read,
  output logic [ADDR_W-1:0] o_rom_address,
  input  logic [DATA_W-1:0] i_rom_data,
  input  logic              i_rom_valid,
  output logic              o_timeout,
  output logic              o_overrun
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state;
  logic              pend0, pend1;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic              grant;
  logic              last_grant;
  logic [CNT_W-1:0]  wait_cnt;

  logic rom_done, time_up, finish, done0, done1, pick;

  // A port "completes" in the WAIT cycle whose edge registers its strobe;
  // valid data takes priority over a timeout reached in the same cycle.
  always_comb begin
    rom_done = (state == S_WAIT) && i_rom_valid;
    time_up  = (state == S_WAIT) && !i_rom_valid && (wait_cnt == CNT_W'(TIMEOUT));
    finish   = rom_done || time_up;
    done0    = finish && !grant;
    done1    = finish && grant;
    pick     = (pend0 && pend1) ? ~last_grant : pend1;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      pend0         <= 1'b0;
      pend1         <= 1'b0;
      addr0_q       <= '0;
      addr1_q       <= '0;
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      wait_cnt      <= '0;
      o_rom_read    <= 1'b0;
      o_rom_address <= '0;
      o_valid0      <= 1'b0;
      o_valid1      <= 1'b0;
      o_data0       <= '0;
      o_data1       <= '0;
      o_timeout     <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_rom_read <= 1'b0;
      o_valid0   <= 1'b0;
      o_valid1   <= 1'b0;
      o_timeout  <= 1'b0;

      // Re-request on the completing cycle wins over the clear.
      if (i_read0 && (!pend0 || done0)) begin
        pend0   <= 1'b1;
        addr0_q <= i_addr0;
      end else if (done0) begin
        pend0 <= 1'b0;
      end

      if (i_read1 && (!pend1 || done1)) begin
        pend1   <= 1'b1;
        addr1_q <= i_addr1;
      end else if (done1) begin
        pend1 <= 1'b0;
      end

      if ((i_read0 && pend0 && !done0) || (i_read1 && pend1 && !done1)) begin
        o_overrun <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pend0 || pend1) begin
            grant         <= pick;
            last_grant    <= pick;
            o_rom_read    <= 1'b1;
            o_rom_address <= pick ? addr1_q : addr0_q;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (rom_done) begin
            if (grant) begin
              o_data1  <= i_rom_data;
              o_valid1 <= 1'b1;
            end else begin
              o_data0  <= i_rom_data;
              o_valid0 <= 1'b1;
            end
            state <= S_IDLE;
          end else if (time_up) begin
            if (grant) begin
              o_data1  <= '0;
              o_valid1 <= 1'b1;
            end else begin
              o_data0  <= '0;
              o_valid0 <= 1'b1;
            end
            o_timeout <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter: single reads, round-robin,
// timeout, overrun, re-request on completion and mid-transaction reset.
module tb_rom_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read0 = 1'b0, read1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] data0, data1;
  logic              valid0, valid1;
  logic              rom_read;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_data = '0;
  logic              rom_valid = 1'b0;
  logic              timeout, overrun;

  int errors = 0;
  int checks = 0;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_read0(read0), .i_addr0(addr0), .o_data0(data0), .o_valid0(valid0),
    .i_read1(read1), .i_addr1(addr1), .o_data1(data1), .o_valid1(valid1),
    .o_rom_read(rom_read), .o_rom_address(rom_address),
    .i_rom_data(rom_data), .i_rom_valid(rom_valid),
    .o_timeout(timeout), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_read"}, rom_read, 0);
    check({tag, "_rom_addr"}, rom_address, 0);
    check({tag, "_valid0"}, valid0, 0);
    check({tag, "_valid1"}, valid1, 0);
    check({tag, "_data0"}, data0, 0);
    check({tag, "_data1"}, data1, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    read0 = 1'b0; read1 = 1'b0; rom_valid = 1'b0; rom_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Bounded wait for an ISSUE cycle; an expired bound is a failed check.
  task automatic wait_issue(input string tag);
    int n = 0;
    while (rom_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_issue"}, rom_read, 1);
  endtask

  // Called with ISSUE visible: answers after `delay` extra WAIT cycles.
  task automatic serve(input string tag, input logic port, input logic [DATA_W-1:0] d,
                       input int delay);
    tick();
    repeat (delay) tick();
    rom_valid = 1'b1;
    rom_data  = d;
    tick();
    rom_valid = 1'b0;
    rom_data  = 24'hDEAD00;
    check({tag, "_valid"}, port ? valid1 : valid0, 1);
    check({tag, "_other_valid"}, port ? valid0 : valid1, 0);
    check({tag, "_data"}, port ? data1 : data0, d);
    check({tag, "_no_timeout"}, timeout, 0);
    tick();
    check({tag, "_valid_pulse"}, port ? valid1 : valid0, 0);
    check({tag, "_data_hold"}, port ? data1 : data0, d);
  endtask

  initial begin
    // Reset values while reset is asserted
    #1;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;

    // Single port-0 read with minimum-latency ISSUE
    read0 = 1'b1; addr0 = 9'h012;
    tick();
    read0 = 1'b0;
    check("t1_rom_read_early", rom_read, 0);
    tick();
    check("t1_rom_read", rom_read, 1);
    check("t1_rom_addr", rom_address, 9'h012);
    serve("t1", 1'b0, 24'hA1B2C3, 1);
    check("t1_addr_hold", rom_address, 9'h012);

    // Simultaneous pair after reset: port 0 first; a pair presented in the
    // port-0 completion cycle is then served port 1 first
    do_reset();
    read0 = 1'b1; addr0 = 9'h001;
    read1 = 1'b1; addr1 = 9'h002;
    tick();
    read0 = 1'b0; read1 = 1'b0;
    wait_issue("t2a");
    check("t2a_addr", rom_address, 9'h001);
    tick();
    rom_valid = 1'b1; rom_data = 24'h000111;
    read0 = 1'b1; addr0 = 9'h003;
    read1 = 1'b1; addr1 = 9'h004;
    tick();
    rom_valid = 1'b0; read0 = 1'b0; read1 = 1'b0;
    check("t2a_valid0", valid0, 1);
    check("t2a_data0", data0, 24'h000111);
    check("t2a_overrun", overrun, 1);
    wait_issue("t2b");
    check("t2b_addr_port1_first", rom_address, 9'h002);
    serve("t2b", 1'b1, 24'h000222, 0);
    wait_issue("t2c");
    check("t2c_addr_port0", rom_address, 9'h003);
    serve("t2c", 1'b0, 24'h000333, 0);

    // Timeout on port 1 after 16 WAIT cycles with data forced to 0
    do_reset();
    read1 = 1'b1; addr1 = 9'h0AA;
    tick();
    read1 = 1'b0;
    wait_issue("t3a");
    serve("t3a", 1'b1, 24'h123456, 2);
    read1 = 1'b1; addr1 = 9'h0BB;
    tick();
    read1 = 1'b0;
    wait_issue("t3b");
    check("t3b_addr", rom_address, 9'h0BB);
    repeat (16) tick();
    check("t3b_timeout_early", timeout, 0);
    tick();
    check("t3b_timeout", timeout, 1);
    check("t3b_valid1", valid1, 1);
    check("t3b_data1_zero", data1, 0);
    check("t3b_valid0", valid0, 0);
    tick();
    check("t3b_timeout_pulse", timeout, 0);
    check("t3b_valid1_pulse", valid1, 0);
    read0 = 1'b1; addr0 = 9'h0CC;
    tick();
    read0 = 1'b0;
    tick();
    check("t3c_idle_reissue", rom_read, 1);
    check("t3c_addr", rom_address, 9'h0CC);
    // Valid arriving exactly when the counter reaches TIMEOUT is data
    repeat (16) tick();
    rom_valid = 1'b1; rom_data = 24'h5A5A5A;
    tick();
    rom_valid = 1'b0;
    check("t3c_valid0", valid0, 1);
    check("t3c_data0", data0, 24'h5A5A5A);
    check("t3c_no_timeout", timeout, 0);

    // Overrun: second port-0 request while pending is dropped
    do_reset();
    read0 = 1'b1; addr0 = 9'h044;
    tick();
    addr0 = 9'h055;
    tick();
    read0 = 1'b0;
    check("t4_overrun", overrun, 1);
    wait_issue("t4");
    check("t4_addr_first", rom_address, 9'h044);
    serve("t4", 1'b0, 24'h0F0F0F, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_second_issue", rom_read, 0);
    end
    check("t4_overrun_sticky", overrun, 1);

    // Re-request on port 1 in its o_valid1 cycle
    do_reset();
    read1 = 1'b1; addr1 = 9'h010;
    tick();
    read1 = 1'b0;
    wait_issue("t5a");
    tick();
    rom_valid = 1'b1; rom_data = 24'hABCDEF;
    tick();
    rom_valid = 1'b0;
    check("t5a_valid1", valid1, 1);
    read1 = 1'b1; addr1 = 9'h020;
    tick();
    read1 = 1'b0;
    wait_issue("t5b");
    check("t5b_addr", rom_address, 9'h020);
    check("t5b_overrun", overrun, 0);

    // Reset mid-WAIT, then a late ROM valid is ignored
    do_reset();
    read0 = 1'b1; addr0 = 9'h077;
    tick();
    read0 = 1'b0;
    wait_issue("t6");
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    tick();
    rst_n = 1'b1;
    rom_valid = 1'b1; rom_data = 24'h777777;
    tick();
    rom_valid = 1'b0;
    check("t6_late_valid0", valid0, 0);
    check("t6_late_valid1", valid1, 0);
    check("t6_late_data0", data0, 0);
    tick();
    check("t6_no_issue", rom_read, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
